// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception/redirect controller.
//   - ExcCode values written into Cause[6:2]
//   - CP0 register numbers decoded by the mfc0 read port
//   - controller state encoding, EPC source select, per-stage flush mask
//   - Cause field positions
package exc_pkg;

    // ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // CP0 register numbers
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_EXC_MSB = 6;
    localparam int unsigned CAUSE_IP2     = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    // Which pipeline stage supplies EPC for an accepted exception
    typedef enum logic {
        EPC_EX = 1'b0,
        EPC_ID = 1'b1
    } epc_src_e;

    typedef struct packed {
        logic fl_if;
        logic fl_id;
        logic fl_ex;
    } flush_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline <-> exception controller bundle.
//   master : pipeline side (drives requests, handler vector, mfc0 select)
//   slave  : exc_ctrl side (drives flushes, redirect, CP0 state, read data)
// Signals:
//   exceptAddr, ex_ov/ex_pc, id_ri/id_pc, id_eret, int_req (EXC_INT_EN only),
//   cp0_rd_sel/cp0_rd_data, flush_if/id/ex, redirect_valid/redirect_pc,
//   busy, exl, Cause, EPC.
interface exc_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] exceptAddr;
    logic              ex_ov;
    logic [DATA_W-1:0] ex_pc;
    logic              id_ri;
    logic [DATA_W-1:0] id_pc;
    logic              id_eret;
`ifdef EXC_INT_EN
    logic              int_req;
`endif
    logic [4:0]        cp0_rd_sel;
    logic [DATA_W-1:0] cp0_rd_data;
    logic              flush_if;
    logic              flush_id;
    logic              flush_ex;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              busy;
    logic              exl;
    logic [DATA_W-1:0] Cause;
    logic [DATA_W-1:0] EPC;

    modport master (
        output exceptAddr, ex_ov, ex_pc, id_ri, id_pc, id_eret, cp0_rd_sel,
`ifdef EXC_INT_EN
        output int_req,
`endif
        input  cp0_rd_data, flush_if, flush_id, flush_ex, redirect_valid, redirect_pc,
        input  busy, exl, Cause, EPC
    );

    modport slave (
        input  exceptAddr, ex_ov, ex_pc, id_ri, id_pc, id_eret, cp0_rd_sel,
`ifdef EXC_INT_EN
        input  int_req,
`endif
        output cp0_rd_data, flush_if, flush_id, flush_ex, redirect_valid, redirect_pc,
        output busy, exl, Cause, EPC
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational event selection for exc_ctrl.
// Priority (oldest instruction first): ex_ov > id_ri > int_req > id_eret.
// int_req only counts when exl=0, id_eret only when exl=1.
// Ports:
//   en       in  controller is idle and not in reset
//   exl      in  current Status.EXL
//   ex_ov, id_ri, id_eret, int_req (EXC_INT_EN only)  in  event requests
//   accept   out an event is taken this cycle
//   eret     out the taken event is ERET (otherwise an exception)
//   code     out ExcCode for Cause[6:2]
//   epc_src  out stage whose PC becomes EPC
//   flush    out same-cycle flush mask
// Build option: EXC_INT_EN adds the int_req input and interrupt path.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic     en,
    input  logic     exl,
    input  logic     ex_ov,
    input  logic     id_ri,
`ifdef EXC_INT_EN
    input  logic     int_req,
`endif
    input  logic     id_eret,
    output logic     accept,
    output logic     eret,
    output logic [4:0] code,
    output epc_src_e epc_src,
    output flush_t   flush
);

    always_comb begin
        accept  = 1'b0;
        eret    = 1'b0;
        code    = EXC_INT;
        epc_src = EPC_ID;
        flush   = '0;
        if (en) begin
            if (ex_ov) begin
                accept  = 1'b1;
                code    = EXC_OV;
                epc_src = EPC_EX;
                flush   = '{fl_if: 1'b1, fl_id: 1'b1, fl_ex: 1'b1};
            end else if (id_ri) begin
                accept  = 1'b1;
                code    = EXC_RI;
                flush   = '{fl_if: 1'b1, fl_id: 1'b1, fl_ex: 1'b0};
`ifdef EXC_INT_EN
            end else if (int_req && !exl) begin
                accept  = 1'b1;
                code    = EXC_INT;
                flush   = '{fl_if: 1'b1, fl_id: 1'b1, fl_ex: 1'b0};
`endif
            end else if (id_eret && exl) begin
                accept  = 1'b1;
                eret    = 1'b1;
                flush   = '{fl_if: 1'b1, fl_id: 1'b0, fl_ex: 1'b0};
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0-lite exception/redirect controller for the pipelined MIPS core.
// Accepts exceptions/ERET in IDLE, latches Cause/EPC, flushes stages, then
// issues a one-cycle PC redirect (handler on exception, EPC on ERET).
// Ports:
//   CLK    in  system clock, rising edge
//   Reset  in  synchronous active-high reset; all outputs forced to 0 while high
//   bus    exc_ctrl_if.slave (requests, flushes, redirect, CP0 state, mfc0 port)
// Parameters:
//   FLUSH_CYCLES  cycles in FLUSH before redirect (1..7)
//   DATA_W        width of PC, EPC, Cause and CP0 read data
// Build option: EXC_INT_EN enables the int_req interrupt path and Cause[10] (IP2).
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned DATA_W       = 32
) (
    input logic      CLK,
    input logic      Reset,
    exc_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic              exl_q, exl_d;
    logic [DATA_W-1:0] rpc_q, rpc_d;

    logic              acc;
    logic              acc_eret;
    logic [4:0]        acc_code;
    epc_src_e          acc_epc_src;
    flush_t            acc_flush;

    flush_t            flush;
    logic              redirect_valid;
    logic              busy;
    logic [DATA_W-1:0] rd_data;

    exc_prio_enc u_prio (
        .en      (state_q == IDLE && !Reset),
        .exl     (exl_q),
        .ex_ov   (bus.ex_ov),
        .id_ri   (bus.id_ri),
`ifdef EXC_INT_EN
        .int_req (bus.int_req),
`endif
        .id_eret (bus.id_eret),
        .accept  (acc),
        .eret    (acc_eret),
        .code    (acc_code),
        .epc_src (acc_epc_src),
        .flush   (acc_flush)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            epc_q   <= '0;
            exl_q   <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            exl_q   <= exl_d;
            rpc_q   <= rpc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        exl_d          = exl_q;
        rpc_d          = rpc_q;
        flush          = '0;
        redirect_valid = 1'b0;
        busy           = 1'b0;

        unique case (state_q)
            IDLE: begin
                flush = acc_flush;
                if (acc) begin
                    if (acc_eret) begin
                        exl_d   = 1'b0;
                        rpc_d   = epc_q;
                        state_d = REDIRECT;
                    end else begin
                        cause_d = '0;
                        cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = acc_code;
                        // Nested exception keeps the original return address
                        if (!exl_q) begin
                            epc_d = (acc_epc_src == EPC_EX) ? bus.ex_pc : bus.id_pc;
                        end
                        exl_d   = 1'b1;
                        rpc_d   = bus.exceptAddr;
                        cnt_d   = 3'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush = '{fl_if: 1'b1, fl_id: 1'b1, fl_ex: 1'b1};
                busy  = 1'b1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            REDIRECT: begin
                flush.fl_if    = 1'b1;
                redirect_valid = 1'b1;
                busy           = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef EXC_INT_EN
        // IP2 tracks the interrupt line regardless of state
        cause_d[CAUSE_IP2] = bus.int_req;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (bus.cp0_rd_sel)
            CP0_STATUS: rd_data = {{(DATA_W-1){1'b0}}, exl_q};
            CP0_CAUSE:  rd_data = cause_q;
            CP0_EPC:    rd_data = epc_q;
            default:    rd_data = '0;
        endcase
    end

    // Everything is held at zero while Reset is asserted
    assign bus.flush_if       = !Reset && flush.fl_if;
    assign bus.flush_id       = !Reset && flush.fl_id;
    assign bus.flush_ex       = !Reset && flush.fl_ex;
    assign bus.redirect_valid = !Reset && redirect_valid;
    assign bus.busy           = !Reset && busy;
    assign bus.redirect_pc    = Reset ? '0 : rpc_q;
    assign bus.exl            = !Reset && exl_q;
    assign bus.Cause          = Reset ? '0 : cause_q;
    assign bus.EPC            = Reset ? '0 : epc_q;
    assign bus.cp0_rd_data    = Reset ? '0 : rd_data;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl (FLUSH_CYCLES=1).
module tb_exc_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    exc_ctrl_if #(.DATA_W(32)) bus ();

    exc_ctrl #(
        .FLUSH_CYCLES (1),
        .DATA_W       (32)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.ex_ov   = 1'b0;
        bus.id_ri   = 1'b0;
        bus.id_eret = 1'b0;
`ifdef EXC_INT_EN
        bus.int_req = 1'b0;
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_req();
        bus.exceptAddr = 32'h500;
        bus.ex_pc      = 32'h0;
        bus.id_pc      = 32'h0;
        bus.cp0_rd_sel = 5'd13;

        // Reset held: outputs zero even with a request present
        bus.ex_ov = 1'b1;
        tick();
        tick();
        chk1("rst_flush_ex", bus.flush_ex, 1'b0);
        chk1("rst_rv", bus.redirect_valid, 1'b0);
        chk32("rst_cause", bus.Cause, 32'h0);
        bus.ex_ov = 1'b0;
        rst = 1'b0;
        #1;
        chk32("rel_cause", bus.Cause, 32'h0);
        chk32("rel_epc", bus.EPC, 32'h0);
        chk1("rel_exl", bus.exl, 1'b0);
        chk1("rel_rv", bus.redirect_valid, 1'b0);
        chk32("rel_rd13", bus.cp0_rd_data, 32'h0);
        chk1("rel_busy", bus.busy, 1'b0);

        // ov + ri together: ov wins
        tick();
        bus.ex_ov = 1'b1;
        bus.id_ri = 1'b1;
        bus.ex_pc = 32'h320;
        bus.id_pc = 32'h324;
        #1;
        chk1("ov_fl_if", bus.flush_if, 1'b1);
        chk1("ov_fl_id", bus.flush_id, 1'b1);
        chk1("ov_fl_ex", bus.flush_ex, 1'b1);
        chk1("ov_busy0", bus.busy, 1'b0);
        tick();
        clear_req();
        #1;
        chk1("ov_flush_st_ex", bus.flush_ex, 1'b1);
        chk1("ov_flush_busy", bus.busy, 1'b1);
        chk1("ov_flush_rv", bus.redirect_valid, 1'b0);
        chk32("ov_cause", bus.Cause, 32'h30);
        chk32("ov_epc", bus.EPC, 32'h320);
        chk1("ov_exl", bus.exl, 1'b1);
        tick();
        chk1("ov_rv", bus.redirect_valid, 1'b1);
        chk32("ov_rpc", bus.redirect_pc, 32'h500);
        chk1("ov_rd_fl_if", bus.flush_if, 1'b1);
        chk1("ov_rd_fl_ex", bus.flush_ex, 1'b0);
        tick();
        chk1("ov_idle_rv", bus.redirect_valid, 1'b0);
        chk1("ov_idle_busy", bus.busy, 1'b0);
        bus.cp0_rd_sel = 5'd12;
        #1;
        chk32("rd12", bus.cp0_rd_data, 32'h1);
        bus.cp0_rd_sel = 5'd13;
        #1;
        chk32("rd13", bus.cp0_rd_data, 32'h30);
        bus.cp0_rd_sel = 5'd14;
        #1;
        chk32("rd14", bus.cp0_rd_data, 32'h320);
        bus.cp0_rd_sel = 5'd5;
        #1;
        chk32("rd5", bus.cp0_rd_data, 32'h0);

        // ERET with exl=1: redirect next cycle to EPC
        bus.id_eret = 1'b1;
        #1;
        chk1("eret_fl_if", bus.flush_if, 1'b1);
        chk1("eret_fl_id", bus.flush_id, 1'b0);
        tick();
        clear_req();
        #1;
        chk1("eret_rv", bus.redirect_valid, 1'b1);
        chk32("eret_rpc", bus.redirect_pc, 32'h320);
        chk1("eret_exl", bus.exl, 1'b0);
        tick();
        chk1("eret_idle_rv", bus.redirect_valid, 1'b0);

        // ERET with exl=0: ignored
        bus.id_eret = 1'b1;
        #1;
        chk1("eret0_fl_if", bus.flush_if, 1'b0);
        tick();
        clear_req();
        #1;
        chk1("eret0_rv", bus.redirect_valid, 1'b0);
        chk1("eret0_busy", bus.busy, 1'b0);

        // Take an ov at 0x600 so exl=1, then a nested ri
        bus.ex_ov = 1'b1;
        bus.ex_pc = 32'h600;
        tick();
        clear_req();
        tick();
        tick();
        chk1("nest_pre_exl", bus.exl, 1'b1);
        chk32("nest_pre_epc", bus.EPC, 32'h600);
        bus.id_ri      = 1'b1;
        bus.id_pc      = 32'h534;
        bus.exceptAddr = 32'h700;
        #1;
        chk1("ri_fl_id", bus.flush_id, 1'b1);
        chk1("ri_fl_ex", bus.flush_ex, 1'b0);
        tick();
        clear_req();
        bus.ex_ov = 1'b1; // squashed request during FLUSH
        bus.ex_pc = 32'h900;
        #1;
        chk32("ri_cause", bus.Cause, 32'h28);
        chk32("ri_epc_hold", bus.EPC, 32'h600);
        tick();
        chk1("ri_rv", bus.redirect_valid, 1'b1);
        chk32("ri_rpc", bus.redirect_pc, 32'h700);
        chk32("ri_cause_ign", bus.Cause, 32'h28);
        clear_req();
        tick();
        chk1("ri_idle_rv", bus.redirect_valid, 1'b0);

        // Reset during FLUSH aborts with no redirect
        bus.id_ri = 1'b1;
        tick();
        clear_req();
        #1;
        chk1("ab_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("ab_rst_fl_ex", bus.flush_ex, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk1("ab_rv0", bus.redirect_valid, 1'b0);
        chk1("ab_busy0", bus.busy, 1'b0);
        chk1("ab_exl", bus.exl, 1'b0);
        tick();
        chk1("ab_rv1", bus.redirect_valid, 1'b0);
        chk1("ab_busy1", bus.busy, 1'b0);

`ifdef EXC_INT_EN
        // Interrupt with exl=0
        bus.int_req = 1'b1;
        bus.id_pc   = 32'h450;
        #1;
        chk1("int_fl_id", bus.flush_id, 1'b1);
        chk1("int_fl_ex", bus.flush_ex, 1'b0);
        tick();
        chk32("int_epc", bus.EPC, 32'h450);
        chk32("int_cause", bus.Cause, 32'h400);
        chk1("int_exl", bus.exl, 1'b1);
        tick();
        chk1("int_rv", bus.redirect_valid, 1'b1);
        chk32("int_rpc", bus.redirect_pc, 32'h700);
        tick();
        // Still asserted but exl=1: not accepted
        chk1("int_x_fl_if", bus.flush_if, 1'b0);
        tick();
        chk1("int_x_busy", bus.busy, 1'b0);
        chk32("int_x_cause", bus.Cause, 32'h400);
        bus.int_req = 1'b0;
        tick();
        chk32("int_ip2_clr", bus.Cause, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/redirect controller (CP0-lite) for the pipelined MIPS core. It receives exception requests from the pipeline, latches Cause and EPC, and flushes the affected stages. It then drives a one-cycle PC redirect to the handler at exceptAddr, or back to EPC on ERET. It exposes Cause, EPC and Status through a read port for mfc0 and the top-level debug outputs.

Parameters:
FLUSH_CYCLES, 1, cycles spent in FLUSH state before redirect (1..7)
DATA_W, 32, width of PC, EPC, Cause and the CP0 read data

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
exceptAddr  in  DATA_W  handler vector, sampled when an exception is accepted
ex_ov  in  1  arithmetic overflow from the EX-stage instruction
ex_pc  in  DATA_W  PC of the EX-stage instruction
id_ri  in  1  reserved/illegal instruction decoded in ID
id_pc  in  DATA_W  PC of the ID-stage instruction
id_eret  in  1  ERET decoded in ID
int_req  in  1  external interrupt, level (present only with EXC_INT_EN)
cp0_rd_sel  in  5  CP0 register number for mfc0
cp0_rd_data  out  DATA_W  CP0 read data, combinational
flush_if, flush_id, flush_ex  out  1  per-stage flush (bubble insert)
redirect_valid  out  1  PC mux must take redirect_pc this cycle
redirect_pc  out  DATA_W  next PC when redirect_valid=1
busy  out  1  high in FLUSH/REDIRECT
exl  out  1  Status.EXL
Cause  out  DATA_W  Cause register
EPC  out  DATA_W  EPC register

Behaviour:
- Reset (sync, Reset=1 at an edge): state=IDLE, Cause=0, EPC=0, exl=0, redirect_pc=0, internal counter=0. All outputs are 0 while Reset is held. A reset mid-FLUSH/REDIRECT aborts at that edge with no redirect.
- States: IDLE, FLUSH, REDIRECT. Event acceptance happens only in IDLE.
- Priority among events (oldest first): ex_ov > id_ri > int_req > id_eret.
- int_req is accepted only when exl=0.
- id_eret is accepted only when exl=1; otherwise it is ignored.
- Accept in cycle N, same-cycle combinational flushes:
  - ex_ov: flush_if, flush_id, flush_ex.
  - id_ri, int_req: flush_if, flush_id.
  - eret: flush_if.
- Exception accept, at edge ending N:
  - Cause[6:2]=ExcCode (Ov=12, RI=10, Int=0); other Cause bits 0, except Cause[10] with EXC_INT_EN.
  - EPC=ex_pc for ov, id_pc for ri/int. EPC is updated only if exl was 0; if exl was 1, Cause updates but EPC holds.
  - exl=1, redirect_pc=exceptAddr, counter=FLUSH_CYCLES, state=FLUSH.
- FLUSH: all three flushes high. counter decrements each cycle; at 1, go to REDIRECT.
- ERET accept, at edge: exl=0, redirect_pc=EPC, state=REDIRECT. FLUSH is skipped.
- REDIRECT: redirect_valid=1 for exactly one cycle, flush_if=1, then IDLE.
- Latency: exception in cycle N -> redirect_valid in cycle N+1+FLUSH_CYCLES. ERET in N -> redirect in N+1.
- Requests during FLUSH/REDIRECT are ignored; they belong to squashed instructions.
- cp0_rd_data: sel 12 -> {31'b0, exl}; 13 -> Cause; 14 -> EPC; any other value -> 0.

Optional Feature:
- EXC_INT_EN defined: int_req is a live input. Cause[10] (IP2) mirrors registered int_req every cycle. Interrupts are taken per the priority rules above.
- EXC_INT_EN undefined: int_req port is absent, Cause[10]=0 always, and no interrupt path is synthesized.

Decomposition:
- Package exc_pkg holds:
  - ExcCode constants: EXC_INT=0, EXC_RI=10, EXC_OV=12.
  - CP0 register numbers: 12, 13, 14.
  - State enum: IDLE, FLUSH, REDIRECT.
  - Cause field positions.
- One sub-module, exc_prio_enc: combinational priority select producing accept, code, epc_src and the flush mask.

Test Plan:
- Reset=1 for 2 cycles, then release -> Cause=0, EPC=0, exl=0, redirect_valid=0, cp0_rd_data(sel 13)=0.
- ex_ov=1, ex_pc=0x320, exceptAddr=0x500, FLUSH_CYCLES=1 -> same cycle flush_if/id/ex=1. Next cycle (FLUSH) flushes=1. Following cycle redirect_valid=1, redirect_pc=0x500. EPC=0x320, Cause=0x30, exl=1.
- ex_ov and id_ri together with id_pc=0x324 -> ov wins: Cause=0x30, EPC=ex_pc, flush_ex=1.
- After the ov exception, id_eret=1 -> next cycle redirect_valid=1, redirect_pc=0x320, exl=0. A second id_eret with exl=0 -> no redirect.
- id_ri at id_pc=0x534 while exl=1 -> Cause=0x28, EPC unchanged, redirect to exceptAddr.
- EXC_INT_EN: int_req=1 with exl=0 and id_pc=0x450 -> EPC=0x450, Cause[6:2]=0, Cause[10]=1. int_req=1 while exl=1 -> no accept. Reset asserted during FLUSH -> no redirect_valid, state IDLE.
